// File: rtl/spcore_seq_if.sv
// Issue/memory bus of the spcore_seq sequential core.
// The master drives instructions and memory read data; the core (slave) returns handshake and results.
interface spcore_seq_if #(
   parameter int DATA_W = 16,
   parameter int NREG   = 16
);
   localparam int RA_W = (NREG > 1) ? $clog2(NREG) : 1;

   logic              issue_valid;
   logic              issue_ready;
   logic [RA_W-1:0]   x;
   logic [RA_W-1:0]   y;
   logic [RA_W-1:0]   z;
   logic [3:0]        aluc;
   logic [1:0]        s2;
   logic [DATA_W-1:0] I;
   logic              pred;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic [DATA_W-1:0] addr;
   logic              P;
   logic              done;

   modport master (
      output issue_valid, x, y, z, aluc, s2, I, pred, data_in,
      input  issue_ready, data_out, addr, P, done
   );

   modport slave (
      input  issue_valid, x, y, z, aluc, s2, I, pred, data_in,
      output issue_ready, data_out, addr, P, done
   );
endinterface

// File: rtl/spcore_seq.sv
// Single-issue sequential core: IDLE -> EXE -> (MUL2) -> WB, one instruction in flight.
// Optional predication is enabled by defining SPCORE_PRED_EN.
package spcore_seq_pkg;
   localparam logic [3:0] ALUC_ADD     = 4'h0;
   localparam logic [3:0] ALUC_MUL     = 4'h1;
   localparam logic [3:0] ALUC_MAD     = 4'h2;
   localparam logic [3:0] ALUC_INC     = 4'h3;
   localparam logic [3:0] ALUC_CLEAR   = 4'h4;
   localparam logic [3:0] ALUC_CORE_ID = 4'h5;
   localparam logic [3:0] ALUC_N_CORES = 4'h6;
   localparam logic [3:0] ALUC_EQ      = 4'h7;
   localparam logic [3:0] ALUC_LT      = 4'h8;

   localparam logic [1:0] MUXD_FROM_I   = 2'd0;
   localparam logic [1:0] MUXD_FROM_ALU = 2'd1;
   localparam logic [1:0] MUXD_FROM_MEM = 2'd2;
endpackage

module spcore_seq
   import spcore_seq_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int NREG    = 16,
   parameter int CORE_ID = 0,
   parameter int N_CORES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   spcore_seq_if.slave        bus
);
   localparam int RA_W = (NREG > 1) ? $clog2(NREG) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXE,
      S_MUL2,
      S_WB
   } state_e;

   state_e            r_state;
   state_e            w_state_next;
   logic              w_accept;

   logic [DATA_W-1:0] r_regs [NREG];
   logic [RA_W-1:0]   r_x;
   logic [RA_W-1:0]   r_y;
   logic [RA_W-1:0]   r_z;
   logic [3:0]        r_aluc;
   logic [1:0]        r_s2;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_result;
   logic [DATA_W-1:0] r_data_out;
   logic [DATA_W-1:0] r_addr;
   logic              r_cmp;
   logic              r_p;
   logic              r_done;

   logic [DATA_W-1:0] w_rx;
   logic [DATA_W-1:0] w_ry;
   logic [DATA_W-1:0] w_rz;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W-1:0] w_wb_data;
   logic              w_cmp;
   logic              w_is_mul;
   logic              w_is_cmp;
   logic              w_wb_en;

   assign w_is_mul = (r_aluc == ALUC_MUL) || (r_aluc == ALUC_MAD);
   assign w_is_cmp = (r_aluc == ALUC_EQ)  || (r_aluc == ALUC_LT);

   assign bus.issue_ready = en && (r_state == S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else if (en) begin
         r_state <= w_state_next;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.issue_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_EXE;
            end
         end
         S_EXE:   w_state_next = w_is_mul ? S_MUL2 : S_WB;
         S_MUL2:  w_state_next = S_WB;
         S_WB:    w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_rx = r_regs[r_x];
   assign w_ry = r_regs[r_y];
   assign w_rz = r_regs[r_z];

   always_comb begin
      w_alu = '0;
      case (r_aluc)
         ALUC_ADD:     w_alu = w_ry + w_rz;
         ALUC_MUL,
         ALUC_MAD:     w_alu = w_ry * w_rz;
         ALUC_INC:     w_alu = w_rx + 1'b1;
         ALUC_CLEAR:   w_alu = '0;
         ALUC_CORE_ID: w_alu = DATA_W'(CORE_ID);
         ALUC_N_CORES: w_alu = DATA_W'(N_CORES);
         default:      w_alu = '0;
      endcase
   end

   assign w_cmp = (r_aluc == ALUC_EQ) ? (w_ry == w_rz) : (w_ry < w_rz);

   always_comb begin
      w_wb_data = r_result;
      case (r_s2)
         MUXD_FROM_I:   w_wb_data = r_imm;
         MUXD_FROM_MEM: w_wb_data = bus.data_in;
         default:       w_wb_data = r_result;
      endcase
   end

`ifdef SPCORE_PRED_EN
   logic r_pred;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pred <= 1'b0;
      end else if (en && w_accept) begin
         r_pred <= bus.pred;
      end
   end

   assign w_wb_en = !(r_pred && !r_p);
`else
   logic w_unused_pred;
   assign w_unused_pred = bus.pred;
   assign w_wb_en       = 1'b1;
`endif

   // NOTE: the register file is cleared by reset because its all-zero state is architecturally visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= '0;
         r_aluc     <= '0;
         r_s2       <= '0;
         r_imm      <= '0;
         r_result   <= '0;
         r_data_out <= '0;
         r_addr     <= '0;
         r_cmp      <= 1'b0;
         r_p        <= 1'b0;
         r_done     <= 1'b0;
      end else if (en) begin
         if (w_accept) begin
            r_x    <= bus.x;
            r_y    <= bus.y;
            r_z    <= bus.z;
            r_aluc <= bus.aluc;
            r_s2   <= bus.s2;
            r_imm  <= bus.I;
         end
         case (r_state)
            S_EXE: begin
               r_data_out <= w_rx;
               r_addr     <= w_ry;
               r_result   <= w_alu;
               r_cmp      <= w_cmp;
            end
            S_MUL2: begin
               // r_data_out already holds R[x] sampled in EXE, the MAD accumulator.
               if (r_aluc == ALUC_MAD) begin
                  r_result <= r_result + r_data_out;
               end
            end
            S_WB: begin
               if (w_wb_en) begin
                  if (w_is_cmp) begin
                     r_p <= r_cmp;
                  end else begin
                     r_regs[r_x] <= w_wb_data;
                  end
               end
            end
            default: ;
         endcase
         r_done <= (r_state == S_WB);
      end else begin
         r_done <= 1'b0;
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.addr     = r_addr;
   assign bus.P        = r_p;
   assign bus.done     = r_done;

endmodule

// File: tb/tb_spcore_seq.sv
// Scoreboard bench for spcore_seq: directed spec scenarios followed by randomized instructions with stalls.
module tb_spcore_seq;
   import spcore_seq_pkg::*;

   localparam int DATA_W  = 16;
   localparam int NREG    = 16;
   localparam int CORE_ID = 100;
   localparam int N_CORES = 4;
   localparam int RA_W    = 4;

   logic clk = 1'b0;
   logic reset;
   logic en;

   spcore_seq_if #(.DATA_W(DATA_W), .NREG(NREG)) bus ();

   spcore_seq #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .CORE_ID(CORE_ID),
      .N_CORES(N_CORES)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] dout;
      logic [15:0] addr;
      logic        p;
      int          done_at;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_errors = 0;
   int          edge_cnt = 0;
   int          stall_pct = 0;
   logic [15:0] m_r [NREG];
   logic        m_p;

   // Counts enabled clock edges: the core only advances on these.
   always @(posedge clk) if (en === 1'b1) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic next_en();
      return ($urandom_range(0, 99) >= stall_pct);
   endfunction

   // Reference model: architectural effect of one instruction on R[] and P.
   task automatic model_exec(input logic [3:0] aluc, input logic [1:0] s2, input int x, input int y,
                             input int z, input logic [15:0] imm, input logic pred, input logic [15:0] din);
      longint rx = m_r[x];
      longint ry = m_r[y];
      longint rz = m_r[z];
      longint res = 0;
      bit     do_write = 1'b1;
`ifdef SPCORE_PRED_EN
      if (pred && !m_p) do_write = 1'b0;
`else
      if (pred === 1'bx) do_write = 1'b1;
`endif
      case (aluc)
         ALUC_ADD:     res = ry + rz;
         ALUC_MUL:     res = ry * rz;
         ALUC_MAD:     res = rx + ry * rz;
         ALUC_INC:     res = rx + 1;
         ALUC_CLEAR:   res = 0;
         ALUC_CORE_ID: res = CORE_ID;
         ALUC_N_CORES: res = N_CORES;
         default:      res = 0;
      endcase
      res = res % 65536;
      if (do_write) begin
         if (aluc == ALUC_EQ)      m_p = (ry == rz);
         else if (aluc == ALUC_LT) m_p = (ry < rz);
         else if (s2 == MUXD_FROM_I)   m_r[x] = imm;
         else if (s2 == MUXD_FROM_MEM) m_r[x] = din;
         else                          m_r[x] = res[15:0];
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         en = next_en();
         t++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic [3:0] aluc, input logic [1:0] s2, input int x, input int y,
                        input int z, input logic [15:0] imm, input logic pred, input bit wait_done);
      bit          acc = 1'b0;
      int          tries = 0;
      exp_t        e;
      logic [15:0] din = 16'($urandom);
      while (!acc && tries < 200) begin
         @(negedge clk);
         en              = next_en();
         tries++;
         bus.issue_valid = 1'b1;
         bus.x           = x[RA_W-1:0];
         bus.y           = y[RA_W-1:0];
         bus.z           = z[RA_W-1:0];
         bus.aluc        = aluc;
         bus.s2          = s2;
         bus.I           = imm;
         bus.pred        = pred;
         bus.data_in     = din;
         #1;
         if (bus.issue_ready === 1'b1) begin
            acc       = 1'b1;
            e.dout    = m_r[x];
            e.addr    = m_r[y];
            e.done_at = edge_cnt + (((aluc == ALUC_MUL) || (aluc == ALUC_MAD)) ? 4 : 3);
            model_exec(aluc, s2, x, y, z, imm, pred, din);
            e.p = m_p;
            sb.push_back(e);
         end
      end
      if (!acc) check("issue_timeout", 0, 1);
      @(negedge clk);
      bus.issue_valid = 1'b0;
      en              = next_en();
      if (wait_done) wait_idle();
   endtask

   task automatic read_reg(input int r);
      issue(ALUC_EQ, MUXD_FROM_ALU, r, r, r, 16'h0, 1'b0, 1'b1);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("data_out",   bus.data_out, mon_e.dout);
            check("addr",       bus.addr,     mon_e.addr);
            check("P",          bus.P,        mon_e.p);
            check("done_cycle", edge_cnt,     mon_e.done_at);
         end
      end
   end

   initial begin
      reset           = 1'b1;
      en              = 1'b1;
      bus.issue_valid = 1'b0;
      bus.x           = '0;
      bus.y           = '0;
      bus.z           = '0;
      bus.aluc        = '0;
      bus.s2          = '0;
      bus.I           = '0;
      bus.pred        = 1'b0;
      bus.data_in     = '0;
      for (int i = 0; i < NREG; i++) m_r[i] = '0;
      m_p = 1'b0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_ready",    bus.issue_ready, 1);
      check("rst_P",        bus.P,           0);
      check("rst_done",     bus.done,        0);
      check("rst_data_out", bus.data_out,    0);
      check("rst_addr",     bus.addr,        0);

      // LOADI, ADD, MAD, then read back R2.
      issue(ALUC_ADD, MUXD_FROM_I,   0, 0, 0, 16'd11, 1'b0, 1'b1);
      issue(ALUC_ADD, MUXD_FROM_I,   1, 0, 0, 16'd20, 1'b0, 1'b1);
      issue(ALUC_ADD, MUXD_FROM_ALU, 2, 0, 1, 16'd0,  1'b0, 1'b1);
      issue(ALUC_MAD, MUXD_FROM_ALU, 2, 0, 1, 16'd0,  1'b0, 1'b1);
      read_reg(2);

      // CORE_ID, CLEAR, LOADI 0xFFFF, INC wrap, N_CORES.
      issue(ALUC_CORE_ID, MUXD_FROM_ALU, 3, 0, 0, 16'd0,    1'b0, 1'b1);
      issue(ALUC_CLEAR,   MUXD_FROM_ALU, 3, 0, 0, 16'd0,    1'b0, 1'b1);
      issue(ALUC_ADD,     MUXD_FROM_I,   3, 0, 0, 16'hFFFF, 1'b0, 1'b1);
      issue(ALUC_INC,     MUXD_FROM_ALU, 3, 0, 0, 16'd0,    1'b0, 1'b1);
      issue(ALUC_N_CORES, MUXD_FROM_ALU, 3, 0, 0, 16'd0,    1'b0, 1'b1);
      read_reg(3);

      // Compares and predication.
      issue(ALUC_EQ,  MUXD_FROM_ALU, 0, 1, 1, 16'd0, 1'b0, 1'b1);
      issue(ALUC_LT,  MUXD_FROM_ALU, 0, 1, 0, 16'd0, 1'b0, 1'b1);
      issue(ALUC_ADD, MUXD_FROM_ALU, 2, 0, 1, 16'd0, 1'b1, 1'b1);
      read_reg(2);

      // Memory load.
      issue(ALUC_ADD, MUXD_FROM_MEM, 5, 0, 0, 16'd0, 1'b0, 1'b1);
      read_reg(5);

      // MUL with five stalled cycles in EXE.
      issue(ALUC_MUL, MUXD_FROM_ALU, 4, 0, 1, 16'd0, 1'b0, 1'b0);
      en = 1'b0;
      repeat (5) @(negedge clk);
      en = 1'b1;
      wait_idle();
      read_reg(4);

      // Reset while in MUL2 aborts the instruction.
      issue(ALUC_MUL, MUXD_FROM_ALU, 6, 0, 1, 16'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NREG; i++) m_r[i] = '0;
      m_p = 1'b0;
      #1;
      check("abort_ready",    bus.issue_ready, 1);
      check("abort_P",        bus.P,           0);
      check("abort_done",     bus.done,        0);
      check("abort_data_out", bus.data_out,    0);
      check("abort_addr",     bus.addr,        0);
      read_reg(0);
      read_reg(6);

      // Randomized instructions with random stalls.
      stall_pct = 20;
      repeat (150) begin
         issue(4'($urandom_range(0, 8)), 2'($urandom_range(0, 2)), int'($urandom_range(0, NREG - 1)),
               int'($urandom_range(0, NREG - 1)), int'($urandom_range(0, NREG - 1)),
               16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end

      stall_pct = 0;
      for (int i = 0; i < NREG; i++) read_reg(i);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spcore_seq.md
SPCORE_SEQ -- requirements
Module: spcore_seq

Interface
REQ-001 Parameter DATA_W, default 16: datapath and register width in bits.
REQ-002 Parameter NREG, default 16: register-file depth; RA_W = clog2(NREG).
REQ-003 Parameter CORE_ID, default 0: value returned by ALUC_CORE_ID.
REQ-004 Parameter N_CORES, default 1: core count, readable via ALUC_N_CORES.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  core clock, all state changes on its rising edge.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 en  in  1  core enable; low freezes all state (stall).
REQ-009 issue_valid  in  1  instruction offered.
REQ-010 issue_ready  out  1  core accepts an instruction this cycle.
REQ-011 x, y, z  in  RA_W each  destination and source register indices.
REQ-012 aluc  in  4  ALU operation, `ALUC_* encodings from constants.v.
REQ-013 s2  in  2  writeback mux select, `MuxD_fromI / `MuxD_fromALU / `MuxD_fromMem.
REQ-014 I  in  DATA_W  immediate.
REQ-015 pred  in  1  instruction is predicated on P.
REQ-016 data_in  in  DATA_W  memory read data.
REQ-017 data_out  out  DATA_W  R[x] of the latched instruction (store data).
REQ-018 addr  out  DATA_W  R[y] of the latched instruction (memory address).
REQ-019 P  out  1  predicate register.
REQ-020 done  out  1  one-cycle pulse in the writeback cycle.

Function
REQ-021 FSM states IDLE, EXE, MUL2, WB; issue_ready = 1 only in IDLE with en = 1.
REQ-022 Acceptance: issue_valid & issue_ready at an edge latches x, y, z, aluc, s2, I, pred and moves IDLE->EXE.
REQ-023 EXE->MUL2 for ALUC_MUL/ALUC_MAD, else EXE->WB; MUL2->WB; WB->IDLE.
REQ-024 Latency: 3 cycles acceptance-to-done for single-cycle ops, 4 for MUL/MAD.
REQ-025 ADD: R[y]+R[z]; MUL: low DATA_W bits of R[y]*R[z]; MAD: R[x]+R[y]*R[z]; all modulo 2^DATA_W.
REQ-026 INC: R[x]+1, wrapping all-ones to 0; CLEAR: 0; CORE_ID/N_CORES: parameter truncated to DATA_W.
REQ-027 ALUC_EQ/ALUC_LT (unsigned) write P in WB with no register write.
REQ-028 WB writes R[x] from I, ALU result or data_in per s2; data_in sampled in WB.
REQ-029 en = 0 holds state, registers, P and outputs; done is not asserted while stalled.
REQ-030 issue_valid outside IDLE is ignored; no queueing.
REQ-031 Register reads use values at EXE; a WB to R[x] is visible to the next accepted instruction.

Reset
REQ-032 Reset forces IDLE, all registers to 0, P = 0, done = 0, data_out = 0, addr = 0.
REQ-033 Reset mid-instruction aborts it; no writeback occurs and done stays 0.
REQ-034 Reset has priority over en.

Configuration
REQ-035 Macro SPCORE_PRED_EN defined: when pred = 1 and P = 0 at WB, the register/P write is suppressed but done still pulses.
REQ-036 Macro SPCORE_PRED_EN undefined: pred is ignored and every instruction writes back.

Verification
REQ-037 LOADI x=0 I=11 then x=1 I=20 -> R0=11, R1=20, each done 3 cycles after acceptance.
REQ-038 ADD x=2 y=0 z=1 -> R2=31; then MAD x=2 y=0 z=1 -> R2=251, done 4 cycles after acceptance.
REQ-039 CORE_ID=100, ALUC_CORE_ID x=3 -> R3=100; CLEAR x=3 -> 0; INC x=3 with R3=0xFFFF (DATA_W=16) -> 0.
REQ-040 EQ y=1 z=1 -> P=1; with SPCORE_PRED_EN, P=0 and pred=1 ADD x=2 -> R2 unchanged, done pulses.
REQ-041 en low for 5 cycles in EXE of MUL -> done delayed exactly 5 cycles, result unchanged.
REQ-042 reset asserted in MUL2 -> next cycle IDLE, all registers 0, P=0, no done pulse.
